// File: rtl/line_buffer_loader.sv
// Loads the raw pixel stream into a ring of zero-bordered row buffers and offers 3-row windows (LB_PROTOCOL_CHECK_EN adds sticky protocol error flags).
// Latency: lb_wr_* are registered one cycle after a column is issued or a pixel is accepted; win_valid follows the completing write by one cycle.
// Backpressure: pixel_i_ready drops, and no new row or pad row starts, while every row buffer is occupied; pad columns never wait on the source.
module line_buffer_loader #(
    parameter int GS_BITS            = 8,
    parameter int D_WIDTH            = 16,
    parameter int PIX_SHIFT          = 0,
    parameter int IMG_DIM            = 28,
    parameter int LINE_BUF_DEPTH     = 30,
    parameter int LINE_BUF_ADDR_BITS = 5,
    parameter int NUM_ROWS           = 4,
    parameter int ROW_SEL_BITS       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GS_BITS-1:0]            pixel_i,
    input  logic                          pixel_i_valid,
    output logic                          pixel_i_ready,
    output logic                          lb_wr_en,
    output logic [ROW_SEL_BITS-1:0]       lb_wr_sel,
    output logic [LINE_BUF_ADDR_BITS-1:0] lb_wr_addr,
    output logic [D_WIDTH-1:0]            lb_wr_data,
    output logic                          win_valid,
    output logic [ROW_SEL_BITS-1:0]       win_base,
    output logic [4:0]                    win_row,
    input  logic                          win_done,
    output logic                          frame_done,
    output logic                          busy,
    output logic [1:0]                    err_o
);

    localparam int RES_BITS = ROW_SEL_BITS + 1;
    localparam logic [LINE_BUF_ADDR_BITS-1:0] LAST_COL  = LINE_BUF_ADDR_BITS'(LINE_BUF_DEPTH - 1);
    localparam logic [LINE_BUF_ADDR_BITS-1:0] LAST_FILL = LINE_BUF_ADDR_BITS'(IMG_DIM);
    localparam logic [RES_BITS-1:0]           ROWS_FULL = RES_BITS'(NUM_ROWS);
    localparam logic [RES_BITS-1:0]           WIN_ROWS  = RES_BITS'(3);
    localparam logic [4:0]                    WIN_LAST  = 5'(IMG_DIM);

    typedef enum logic [2:0] {
        IDLE,
        PAD_TOP,
        FILL_ROW,
        PAD_BOT,
        DRAIN
    } state_t;

    state_t                          state, state_nxt;
    logic [LINE_BUF_ADDR_BITS-1:0]   col, col_nxt;
    logic [LINE_BUF_ADDR_BITS-1:0]   prow, prow_nxt;
    logic [ROW_SEL_BITS-1:0]         wr_ptr, rd_ptr;
    logic [RES_BITS-1:0]             resident;
    logic [RES_BITS-1:0]             occupied;
    logic [D_WIDTH-1:0]              pix_ext;
    logic                            issue, issue_pix, frame_end;
    logic                            row_cmp, row_room, win_adv;

    function automatic logic [ROW_SEL_BITS-1:0] ptr_inc(input logic [ROW_SEL_BITS-1:0] p);
        return (p == ROW_SEL_BITS'(NUM_ROWS - 1)) ? '0 : p + ROW_SEL_BITS'(1);
    endfunction

    // A row whose last write is on lb_wr_* this cycle is not yet counted in
    // resident, but its buffer is spoken for: count it before starting another.
    assign row_cmp  = lb_wr_en && (lb_wr_addr == LAST_COL);
    assign occupied = resident + {{ROW_SEL_BITS{1'b0}}, row_cmp};
    assign row_room = (occupied < ROWS_FULL);

    assign pix_ext   = D_WIDTH'(pixel_i) << PIX_SHIFT;
    assign win_valid = (resident >= WIN_ROWS) && (win_row < WIN_LAST);
    assign win_base  = rd_ptr;
    assign win_adv   = win_valid && win_done;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        prow_nxt      = prow;
        issue         = 1'b0;
        issue_pix     = 1'b0;
        pixel_i_ready = 1'b0;
        frame_end     = 1'b0;

        case (state)
            IDLE: begin
                if (pixel_i_valid) begin
                    state_nxt = PAD_TOP;
                    col_nxt   = '0;
                    prow_nxt  = '0;
                end
            end
            PAD_TOP, PAD_BOT: begin
                issue = (col != '0) || row_room;
            end
            FILL_ROW: begin
                if (col == '0) begin
                    issue = row_room;
                end else if (col == LAST_COL) begin
                    issue = 1'b1;
                end else begin
                    pixel_i_ready = (resident < ROWS_FULL);
                    issue         = pixel_i_ready && pixel_i_valid;
                    issue_pix     = issue;
                end
            end
            DRAIN: begin
                if (win_row == WIN_LAST) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            if (col == LAST_COL) begin
                col_nxt  = '0;
                prow_nxt = prow + LINE_BUF_ADDR_BITS'(1);
                case (state)
                    PAD_TOP:  state_nxt = FILL_ROW;
                    FILL_ROW: state_nxt = (prow == LAST_FILL) ? PAD_BOT : FILL_ROW;
                    PAD_BOT:  state_nxt = DRAIN;
                    default:  state_nxt = state;
                endcase
            end else begin
                col_nxt = col + LINE_BUF_ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            col        <= '0;
            prow       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            resident   <= '0;
            win_row    <= '0;
            lb_wr_en   <= 1'b0;
            lb_wr_sel  <= '0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            prow       <= prow_nxt;
            lb_wr_en   <= issue;
            frame_done <= frame_end;
            if (issue) begin
                lb_wr_sel  <= row_cmp ? ptr_inc(wr_ptr) : wr_ptr;
                lb_wr_addr <= col;
                lb_wr_data <= issue_pix ? pix_ext : '0;
            end
            // The two bottom rows stay resident at frame end; realign the read
            // side so the next frame's first window starts at its own top row.
            if (frame_end) begin
                rd_ptr   <= wr_ptr;
                resident <= '0;
                win_row  <= '0;
            end else begin
                if (row_cmp) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (win_adv) begin
                    rd_ptr  <= ptr_inc(rd_ptr);
                    win_row <= win_row + 5'd1;
                end
                if (row_cmp && !win_adv) begin
                    resident <= resident + RES_BITS'(1);
                end else if (!row_cmp && win_adv) begin
                    resident <= resident - RES_BITS'(1);
                end
            end
        end
    end

`ifdef LB_PROTOCOL_CHECK_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 2'b00;
        end else begin
            if (win_done && !win_valid) begin
                err_q[0] <= 1'b1;
            end
            if (pixel_i_valid && (state == DRAIN)) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_line_buffer_loader.sv
// Randomized bench for line_buffer_loader: a frame-level scoreboard predicts every buffer write and window.
module tb_line_buffer_loader;

    localparam int NPIX = 784;
`ifdef LB_PROTOCOL_CHECK_EN
    localparam logic [1:0] ERR_WD  = 2'b01;
    localparam logic [1:0] ERR_ALL = 2'b11;
`else
    localparam logic [1:0] ERR_WD  = 2'b00;
    localparam logic [1:0] ERR_ALL = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_i;
    logic        pixel_i_valid;
    logic        pixel_i_ready;
    logic        lb_wr_en;
    logic [1:0]  lb_wr_sel;
    logic [4:0]  lb_wr_addr;
    logic [15:0] lb_wr_data;
    logic        win_valid;
    logic [1:0]  win_base;
    logic [4:0]  win_row;
    logic        win_done;
    logic        frame_done;
    logic        busy;
    logic [1:0]  err_o;

    line_buffer_loader dut (
        .clk(clk), .rst(rst),
        .pixel_i(pixel_i), .pixel_i_valid(pixel_i_valid), .pixel_i_ready(pixel_i_ready),
        .lb_wr_en(lb_wr_en), .lb_wr_sel(lb_wr_sel), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
        .win_valid(win_valid), .win_base(win_base), .win_row(win_row), .win_done(win_done),
        .frame_done(frame_done), .busy(busy), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  img [NPIX];
    logic [22:0] exp_q [$];
    int  pix_idx = 0, wcount = 0, fd_cnt = 0, fd_base = 0, exp_win = 0, fbase = 0;
    int  vmode = 0, dmode = 0, cnt = 0;
    bit  prod_en = 0, cons_en = 0, extra_valid = 0, man_done = 0, cons_done = 0;
    bit  acc = 0, tog = 0, armed = 0, wv_prev = 0, prev_last = 0;
    logic [22:0] cap_w = '0;

    assign win_done = man_done | cons_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected write stream of one frame: 30 padded rows, row r lands in buffer (base+r) mod 4.
    task automatic build_frame(input int base);
        logic [15:0] d;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 30; c++) begin
                d = '0;
                if (r >= 1 && r <= 28 && c >= 1 && c <= 28) d = 16'(img[(r-1)*28 + (c-1)]);
                exp_q.push_back({2'((base + r) % 4), 5'(c), d});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wr"}, {lb_wr_en, lb_wr_sel, lb_wr_addr, lb_wr_data}, 0);
        check_val({tag, "_win"}, {win_valid, win_base, win_row}, 0);
        check_val({tag, "_ctl"}, {pixel_i_ready, frame_done, busy}, 0);
        check_val({tag, "_err"}, err_o, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_frame(input bit with_consumer);
        exp_q.delete();
        build_frame(fbase);
        wcount  = 0;
        pix_idx = 0;
        exp_win = 0;
        fd_base = fd_cnt;
        prod_en = 1;
        cons_en = with_consumer;
    endtask

    task automatic finish_frame(input string tag, input int budget);
        int n = 0;
        while (fd_cnt == fd_base && n < budget) begin cycles(1); n++; end
        check_val({tag, "_fd_seen"}, fd_cnt != fd_base, 1);
        cycles(2);
        check_val({tag, "_fd_pulses"}, fd_cnt - fd_base, 1);
        check_val({tag, "_writes"}, wcount, 900);
        check_val({tag, "_exp_left"}, exp_q.size(), 0);
        check_val({tag, "_windows"}, exp_win, 28);
        check_val({tag, "_idle"}, {busy, win_valid, win_row}, 0);
        prod_en = 0;
        cons_en = 0;
        fbase   = (fbase + 30) % 4;
        cycles(2);
    endtask

    task automatic do_reset();
        prod_en = 0; cons_en = 0; extra_valid = 0; man_done = 0;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        fbase = 0;
        exp_q.delete();
        cycles(2);
    endtask

    task automatic pulse_done();
        man_done = 1;
        cycles(1);
        man_done = 0;
    endtask

    // Producer: holds the current pixel, advances only on an observed handshake.
    initial begin
        pixel_i_valid = 1'b0;
        pixel_i = '0;
        forever begin
            @(negedge clk);
            acc = pixel_i_valid && pixel_i_ready;
            @(posedge clk); #1;
            if (acc) pix_idx++;
            tog = !tog;
            if (extra_valid) begin
                pixel_i_valid = 1'b1;
                pixel_i = '0;
            end else if (!prod_en || pix_idx >= NPIX) begin
                pixel_i_valid = 1'b0;
            end else begin
                pixel_i = img[pix_idx];
                case (vmode)
                    0:       pixel_i_valid = 1'b1;
                    1:       pixel_i_valid = tog;
                    default: pixel_i_valid = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // Consumer: releases each window after a delay and checks it is the next one in order.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!cons_en) begin
                armed = 0; cnt = 0; cons_done = 0;
            end else if (cons_done) begin
                cons_done = 0; armed = 0;
            end else if (!armed) begin
                if (win_valid) begin
                    armed = 1;
                    cnt = (dmode == 0) ? 5 : int'($urandom_range(4, 8));
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    check_val("win_order", {win_valid, 2'(win_base), win_row},
                              {1'b1, 2'((fbase + exp_win) % 4), 5'(exp_win)});
                    exp_win++;
                    cons_done = 1;
                end
            end
        end
    end

    // Write scoreboard and window-timing monitor.
    always @(negedge clk) begin
        if (lb_wr_en) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {lb_wr_sel, lb_wr_addr, lb_wr_data}, 0);
            end else begin
                check_val("write", {lb_wr_sel, lb_wr_addr, lb_wr_data}, exp_q.pop_front());
            end
            if (wcount == 125) cap_w = {lb_wr_sel, lb_wr_addr, lb_wr_data};
            wcount++;
        end
        if (win_valid && !wv_prev) check_val("winv_after_col29", prev_last, 1);
        wv_prev   = win_valid;
        prev_last = lb_wr_en && (lb_wr_addr == 5'd29);
        if (frame_done) fd_cnt++;
    end

    initial begin
        int n;
        rst = 1'b0;
        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        cycles(1);

        // Reference image, always-valid source, fixed window delay.
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
        vmode = 0; dmode = 0;
        start_frame(1);
        finish_frame("f1", 6000);
        check_val("f1_pix_r3c4", cap_w, {2'd0, 5'd5, 16'd88});
        check_val("f1_err", err_o, 0);

        // Same image back to back with a toggling source.
        vmode = 1; dmode = 1;
        start_frame(1);
        finish_frame("f2_toggle", 8000);

        // No consumer: four rows fill, then everything stalls.
        do_reset();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        vmode = 0;
        start_frame(0);
        cycles(400);
        check_val("stall_writes", wcount, 120);
        check_val("stall_ready", pixel_i_ready, 0);
        check_val("stall_win", {win_valid, win_base, win_row}, {1'b1, 2'd0, 5'd0});
        cycles(50);
        check_val("stall_hold", {wcount, lb_wr_en}, {32'd120, 1'b0});

        // Release one window, then release another exactly as the next row completes.
        pulse_done();
        check_val("rel1_win", {win_base, win_row}, {2'd1, 5'd1});
        n = 0;
        @(negedge clk);
        while (!(lb_wr_en && lb_wr_addr == 5'd29) && n < 200) begin @(negedge clk); n++; end
        check_val("row4_done_seen", n < 200, 1);
        man_done = 1;
        @(posedge clk); #1;
        man_done = 0;
        check_val("coinc_win", {win_valid, win_base, win_row}, {1'b1, 2'd2, 5'd2});
        cycles(100);
        check_val("coinc_writes", wcount, 180);
        check_val("coinc_hold", {win_valid, win_base, win_row, pixel_i_ready}, {1'b1, 2'd2, 5'd2, 1'b0});

        // Random source and consumer, aborted by reset in the middle of padded row 10.
        do_reset();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        vmode = 2; dmode = 1;
        start_frame(1);
        n = 0;
        while (wcount < 315 && n < 4000) begin cycles(1); n++; end
        check_val("row10_seen", n < 4000, 1);
        rst = 1'b0; prod_en = 0; cons_en = 0;
        cycles(1);
        check_reset_outputs("midreset");
        rst = 1'b1;
        exp_q.delete();
        fbase = 0;
        cycles(3);
        check_val("midreset_quiet", {lb_wr_en, busy}, 0);

        // Stray release while idle, then a full frame with a source that starts early during drain.
        pulse_done();
        cycles(1);
        check_val("err_stray_done", err_o, ERR_WD);
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        start_frame(1);
        n = 0;
        while (wcount < 900 && n < 8000) begin cycles(1); n++; end
        check_val("f3_last_write_seen", n < 8000, 1);
        extra_valid = 1;
        cycles(2);
        extra_valid = 0;
        finish_frame("f3", 2000);
        check_val("err_drain_valid", err_o, ERR_ALL);
        cycles(20);
        check_val("err_sticky", {err_o, busy}, {ERR_ALL, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_loader.md
Name: line_buffer_loader

Overview:
- Sequences the raw MNIST pixel stream (pixel_i/pixel_i_valid) into the ring of padded line buffers that feed CONV2.
- Inserts the 1-pixel zero border, so a 28x28 image becomes 30 rows x 30 columns.
- Tracks row occupancy and presents 3-row windows to the CONV2 engine with a valid/done handshake.
- Back-pressures the pixel source when every row buffer is occupied.

Parameters:
GS_BITS, 8, input pixel width
D_WIDTH, 16, line buffer word width; must be >= GS_BITS+PIX_SHIFT
PIX_SHIFT, 0, left shift applied to the zero-extended pixel (fixed-point alignment)
IMG_DIM, 28, unpadded image height/width
LINE_BUF_DEPTH, 30, words per row buffer (IMG_DIM+2)
LINE_BUF_ADDR_BITS, 5, row buffer address width
NUM_ROWS, 4, physical row buffers in the ring (3 window rows + 1 filling)
ROW_SEL_BITS, 2, clog2(NUM_ROWS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets the block
pixel_i  in  GS_BITS  input pixel, row-major
pixel_i_valid  in  1  pixel present; producer holds pixel until accepted
pixel_i_ready  out  1  pixel accepted on a cycle where valid&&ready
lb_wr_en  out  1  line buffer write strobe
lb_wr_sel  out  ROW_SEL_BITS  physical row buffer being written
lb_wr_addr  out  LINE_BUF_ADDR_BITS  column address 0..29
lb_wr_data  out  D_WIDTH  write data
win_valid  out  1  3 consecutive padded rows are resident
win_base  out  ROW_SEL_BITS  physical buffer holding the window's top row
win_row  out  5  output row index 0..27
win_done  in  1  consumer pulse: window finished, release top row
frame_done  out  1  1-cycle pulse after window 27 is released
busy  out  1  state != IDLE
err_o  out  2  protocol errors (see Optional Feature)

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-low on port rst.
- Reset values: all outputs 0; state=IDLE; wr_ptr=0; rd_ptr=0; resident=0; win_row=0; col=0; padded-row counter prow=0. Reset asserted mid-frame aborts immediately; no partial writes after that edge.
- States:
  - IDLE: pixel_i_valid=1 moves to PAD_TOP. That pixel is not consumed.
  - PAD_TOP: writes padded row 0, 30 zero words at addr 0..29, one per cycle, into buffer wr_ptr. Then goes to FILL_ROW.
  - FILL_ROW (padded rows 1..28):
    - col 0 writes 0 unconditionally.
    - cols 1..28: pixel_i_ready=1 only when resident<NUM_ROWS. The column advances only on valid&&ready.
    - col 29 writes 0.
    - At row end, goes to FILL_ROW if prow<28, else PAD_BOT.
  - PAD_BOT: writes padded row 29 as zeros, then goes to DRAIN.
  - DRAIN: waits until win_row==28, then pulses frame_done and returns to IDLE.
- Stall rules:
  - A new row is not started (col 0 is not issued) while resident==NUM_ROWS. PAD_TOP and PAD_BOT stall the same way.
  - Padding columns never wait on pixel_i_valid.
- Write timing:
  - lb_wr_* are registered and appear 1 cycle after the cycle the column is issued or the pixel is accepted.
  - lb_wr_data = zero-extended pixel << PIX_SHIFT.
- Row completion:
  - wr_ptr increments modulo NUM_ROWS in the cycle after the col-29 write appears.
  - resident increments in that same cycle.
  - Consequence: win_valid rises exactly 1 cycle after the col-29 write of padded row r+2 is on lb_wr_*.
- Window outputs:
  - win_valid = (resident>=3) && (win_row<28).
  - win_base = rd_ptr.
- win_done:
  - Acted on only when win_valid=1: rd_ptr++ (mod NUM_ROWS), resident--, win_row++.
  - When win_valid=0 it is ignored.
  - Row completion and win_done in the same cycle: resident is unchanged, and both pointers advance.
- Wrap-around: wr_ptr and rd_ptr wrap from NUM_ROWS-1 to 0. Buffer contents are never cleared; the pad writes overwrite them.
- Frame throughput: with no stalls, 30 rows x 30 cycles = 900 write cycles per frame. The next frame may start the cycle after frame_done.

Optional Feature:
- Macro: LB_PROTOCOL_CHECK_EN.
- When defined, err_o is a sticky register cleared only by reset:
  - err_o[0] sets on win_done while win_valid=0.
  - err_o[1] sets on pixel_i_valid=1 in DRAIN (producer starting the next frame early).
- When not defined, err_o is tied to 0 and no check logic is built.
- Functional behaviour is identical either way.

Test Plan:
- Reset, then stream a 28x28 image with pixel = (row*28+col) mod 256, valid always 1, win_done pulsed 5 cycles after each win_valid rise:
  - Exactly 900 lb_wr_en cycles.
  - Every addr 0/29 write and all of padded rows 0 and 29 are 0.
  - The pixel at row 3, col 4 is written to addr 5 of buffer (4 mod 4)=0.
  - win_row runs 0..27.
  - One frame_done pulse.
- Never assert win_done:
  - pixel_i_ready drops once 4 rows are resident, i.e. after padded row 3 completes.
  - lb_wr_en stays 0 thereafter.
  - win_valid=1, win_base=0, win_row=0.
- Force win_done in the same cycle resident increments: resident stays constant, and win_base/wr_ptr both advance by 1 mod 4.
- Deassert rst for 1 cycle mid-row 10:
  - Next cycle all outputs are 0 and state is IDLE.
  - A following full frame completes correctly from win_row=0.
- Toggle pixel_i_valid 1/0 every cycle: lb_wr_addr still runs 0..29 per row in order, pad columns take one cycle each, and the output data matches the no-stall run.
- With LB_PROTOCOL_CHECK_EN:
  - win_done while win_valid=0 sets err_o=2'b01 and it stays set.
  - Then valid in DRAIN gives err_o=2'b11.
  - Without the macro, err_o stays 0 for the same stimulus.
